// File: rtl/vga_timing_pkg.sv
// Shared VGA timing: 640x480@60 defaults and derived line/frame totals.
// Used by the sync generator and the renderer so both agree on geometry.
// Also holds the 10-bit counter width and a small window-compare helper.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Inclusive unsigned window test on counter-width values.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up-counter with enable; wrap_o flags the enabled terminal count.
// Latency: count updates one clock after an enabled edge; wrap_o is combinational.
// No backpressure: the counter simply holds while en_i is low.
module wrap_counter #(
  parameter int unsigned MOD = 800,
  parameter int unsigned W   = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: hold, increment, or return to zero on the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v counters decoded into registered sync, blank and x/y.
// Latency: outputs trail the counters by exactly one clock, all mutually aligned.
// No backpressure: pix_en gates advance; everything but frame_tick holds when low.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  output logic             h_sync,
  output logic             v_sync,
  output logic             display_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_tick
);

  localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HA    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VA    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  // End-of-frame strobe from the line counter; nothing here needs it.
  logic             v_wrap_unused;

  wrap_counter #(.MOD(LINE_LEN), .W(CNT_W)) u_h_cnt (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (pix_en),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  // Lines advance only on the enabled pixel that ends a line.
  wrap_counter #(.MOD(FRAME_LINES), .W(CNT_W)) u_v_cnt (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap_unused)
  );

  logic             h_sync_d, h_sync_q;
  logic             v_sync_d, v_sync_q;
  logic             display_on_d, display_on_q;
  logic             frame_tick_d, frame_tick_q;
  logic [CNT_W-1:0] x_q, y_q;

  // Decode the current counter position into the next output values.
  always_comb begin
    h_sync_d     = ~in_window(h_cnt, HS_LO, HS_HI);
    v_sync_d     = ~in_window(v_cnt, VS_LO, VS_HI);
    display_on_d = (h_cnt < HA) && (v_cnt < VA);
    // Tick only when the (0, V_ACTIVE) position is actually being emitted.
    frame_tick_d = pix_en && (h_cnt == '0) && (v_cnt == VA);
  end

  // Output registers: load on enabled pixels; frame_tick is a single-clock pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_sync_q     <= 1'b1;
      v_sync_q     <= 1'b1;
      display_on_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
      if (pix_en) begin
        h_sync_q     <= h_sync_d;
        v_sync_q     <= v_sync_d;
        display_on_q <= display_on_d;
        x_q          <= h_cnt;
        y_q          <= v_cnt;
      end
    end
  end

  assign h_sync     = h_sync_q;
  assign v_sync     = v_sync_q;
  assign display_on = display_on_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default-timing instance for line timing and a miniature
// instance (16x8 raster) for frame-level behaviour, reset and enable gating.
// Expected values are hand-computed from the timing parameters.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 640x480 timing.
  logic       rst_a, en_a, hs_a, vs_a, de_a, ft_a;
  logic [9:0] x_a, y_a;
  // Instance B: H 8+2+3+3=16, V 4+1+2+1=8, frame = 128 clocks.
  logic       rst_b, en_b, hs_b, vs_b, de_b, ft_b;
  logic [9:0] x_b, y_b;

  vga_sync_gen u_dut_a (
    .clock(clk), .reset(rst_a), .pix_en(en_a), .h_sync(hs_a), .v_sync(vs_a),
    .display_on(de_a), .x(x_a), .y(y_a), .frame_tick(ft_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_b (
    .clock(clk), .reset(rst_b), .pix_en(en_b), .h_sync(hs_b), .v_sync(vs_b),
    .display_on(de_b), .x(x_b), .y(y_b), .frame_tick(ft_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk6(input string tag,
                      input logic [9:0] ax, input logic [9:0] ay,
                      input logic ahs, input logic avs, input logic ade, input logic aft,
                      input logic [9:0] ex, input logic [9:0] ey,
                      input logic ehs, input logic evs, input logic ede, input logic eft);
    check({tag, ".x"}, 32'(ax), 32'(ex));
    check({tag, ".y"}, 32'(ay), 32'(ey));
    check({tag, ".h_sync"}, 32'(ahs), 32'(ehs));
    check({tag, ".v_sync"}, 32'(avs), 32'(evs));
    check({tag, ".display_on"}, 32'(ade), 32'(ede));
    check({tag, ".frame_tick"}, 32'(aft), 32'(eft));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    en_b  = 1'b1;
    step();
    step();
    rst_b = 1'b0;
  endtask

  typedef struct {
    int         p;   // pixel index shown: enabled clocks since release minus one
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ft;
  } vec_t;

  vec_t vt[19];

  initial begin
    int cur;
    int run, runs, bad_runs, last_fall, bad_per, ft_cnt, last_ft, bad_ft;
    int vs_low, de_cnt, viol, xy_bad, first_ft;
    logic phs, pvs, pde, pft;
    logic [9:0] px, py;

    vt[0]  = '{0,   10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{7,   10'd7,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{8,   10'd8,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{9,   10'd9,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{10,  10'd10, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{12,  10'd12, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{13,  10'd13, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{15,  10'd15, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{16,  10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{63,  10'd15, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[10] = '{64,  10'd0,  10'd4, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[11] = '{65,  10'd1,  10'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[12] = '{79,  10'd15, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[13] = '{80,  10'd0,  10'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[14] = '{90,  10'd10, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{111, 10'd15, 10'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[16] = '{112, 10'd0,  10'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[17] = '{127, 10'd15, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[18] = '{128, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    // ---- reset state on both instances (pix_en high, reset wins) ----
    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    step(); step(); step();
    chk6("rst_a", x_a, y_a, hs_a, vs_a, de_a, ft_a, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk6("rst_b", x_b, y_b, hs_b, vs_b, de_b, ft_b, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // ---- table: one continuous frame-plus-one on instance B ----
    rst_b = 1'b0;
    cur = -1;
    for (int i = 0; i < 19; i++) begin
      while (cur < vt[i].p) begin
        step();
        cur++;
      end
      chk6($sformatf("vec_p%0d", vt[i].p), x_b, y_b, hs_b, vs_b, de_b, ft_b,
           vt[i].x, vt[i].y, vt[i].hs, vt[i].vs, vt[i].de, vt[i].ft);
    end

    // ---- frame_tick drops and outputs hold while pix_en is low ----
    reset_b();
    for (int i = 0; i < 65; i++) step();
    check("ft_before_hold", 32'(ft_b), 32'd1);
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk6($sformatf("hold%0d", i), x_b, y_b, hs_b, vs_b, de_b, ft_b,
           10'd0, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    en_b = 1'b1;
    step();
    chk6("resume", x_b, y_b, hs_b, vs_b, de_b, ft_b, 10'd1, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0);

    // ---- continuous run on B: widths, periods, counts, alignment ----
    reset_b();
    run = 0; runs = 0; bad_runs = 0; last_fall = -1; bad_per = 0;
    ft_cnt = 0; last_ft = -1; bad_ft = 0; vs_low = 0; de_cnt = 0; viol = 0; xy_bad = 0;
    phs = 1'b1;
    for (int p = 0; p < 300; p++) begin
      step();
      if (x_b !== 10'(p % 16) || y_b !== 10'((p / 16) % 8)) xy_bad++;
      if (hs_b === 1'b0) begin
        if (phs === 1'b1) begin
          if (last_fall >= 0 && p - last_fall != 16) bad_per++;
          last_fall = p;
        end
        run++;
      end else if (run > 0) begin
        runs++;
        if (run != 3) bad_runs++;
        run = 0;
      end
      phs = hs_b;
      if (hs_b !== !(x_b >= 10 && x_b <= 12)) viol++;
      if (vs_b !== !(y_b >= 5 && y_b <= 6)) viol++;
      if (de_b !== (x_b < 8 && y_b < 4)) viol++;
      if (p < 256) begin
        if (vs_b === 1'b0) vs_low++;
        if (de_b === 1'b1) de_cnt++;
      end
      if (ft_b === 1'b1) begin
        ft_cnt++;
        if (x_b !== 10'd0 || y_b !== 10'd4) bad_ft++;
        if (last_ft >= 0 && p - last_ft != 128) bad_ft++;
        last_ft = p;
      end
    end
    check("b_xy_sequence_errors", 32'(xy_bad), 32'd0);
    check("b_hs_runs", 32'(runs), 32'd18);
    check("b_hs_bad_width", 32'(bad_runs), 32'd0);
    check("b_hs_bad_period", 32'(bad_per), 32'd0);
    check("b_decode_violations", 32'(viol), 32'd0);
    check("b_vs_low_2frames", 32'(vs_low), 32'd64);
    check("b_de_high_2frames", 32'(de_cnt), 32'd64);
    check("b_ft_count", 32'(ft_cnt), 32'd2);
    check("b_ft_pos_period", 32'(bad_ft), 32'd0);

    // ---- pix_en every other clock on B ----
    reset_b();
    viol = 0; ft_cnt = 0; last_ft = -1; bad_ft = 0; first_ft = -1;
    px = x_b; py = y_b; phs = hs_b; pvs = vs_b; pde = de_b; pft = ft_b;
    for (int i = 0; i < 600; i++) begin
      en_b = (i % 2 == 0);
      step();
      if (!en_b) begin
        if (x_b !== px || y_b !== py || hs_b !== phs || vs_b !== pvs || de_b !== pde) viol++;
        if (ft_b !== 1'b0) bad_ft++;
      end
      if (ft_b === 1'b1) begin
        ft_cnt++;
        if (first_ft < 0) first_ft = i;
        if (pft === 1'b1) bad_ft++;
        if (last_ft >= 0 && i - last_ft != 256) bad_ft++;
        last_ft = i;
      end
      px = x_b; py = y_b; phs = hs_b; pvs = vs_b; pde = de_b; pft = ft_b;
    end
    en_b = 1'b1;
    check("alt_hold_violations", 32'(viol), 32'd0);
    check("alt_ft_count", 32'(ft_cnt), 32'd2);
    check("alt_ft_first_clock", 32'(first_ft), 32'd128);
    check("alt_ft_width_period", 32'(bad_ft), 32'd0);

    // ---- reset asserted inside both syncs on B ----
    reset_b();
    for (int i = 0; i < 109; i++) step();
    chk6("in_sync", x_b, y_b, hs_b, vs_b, de_b, ft_b, 10'd12, 10'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk6($sformatf("mid_rst%0d", i), x_b, y_b, hs_b, vs_b, de_b, ft_b,
           10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rst_b = 1'b0;
    step();
    chk6("post_rst0", x_b, y_b, hs_b, vs_b, de_b, ft_b, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk6("post_rst1", x_b, y_b, hs_b, vs_b, de_b, ft_b, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0);

    // ---- default timing on A: two-plus lines of horizontal behaviour ----
    rst_a = 1'b0;
    run = 0; runs = 0; bad_runs = 0; last_fall = -1; bad_per = 0; viol = 0; xy_bad = 0;
    phs = 1'b1;
    for (int p = 0; p < 1700; p++) begin
      step();
      if (x_a !== 10'(p % 800) || y_a !== 10'(p / 800)) xy_bad++;
      if (p == 0)
        chk6("a_first", x_a, y_a, hs_a, vs_a, de_a, ft_a, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (p == 639) check("a_de_x639", 32'(de_a), 32'd1);
      if (p == 640) check("a_de_x640", 32'(de_a), 32'd0);
      if (p == 655) check("a_hs_x655", 32'(hs_a), 32'd1);
      if (p == 656) check("a_hs_x656", 32'(hs_a), 32'd0);
      if (p == 751) check("a_hs_x751", 32'(hs_a), 32'd0);
      if (p == 752) check("a_hs_x752", 32'(hs_a), 32'd1);
      if (p == 800)
        chk6("a_line1", x_a, y_a, hs_a, vs_a, de_a, ft_a, 10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      if (hs_a === 1'b0) begin
        if (phs === 1'b1) begin
          if (last_fall >= 0 && p - last_fall != 800) bad_per++;
          last_fall = p;
        end
        run++;
      end else if (run > 0) begin
        runs++;
        if (run != 96) bad_runs++;
        run = 0;
      end
      phs = hs_a;
      if (hs_a !== !(x_a >= 656 && x_a <= 751)) viol++;
      if (de_a !== (x_a < 640)) viol++;
      if (vs_a !== 1'b1 || ft_a !== 1'b0) viol++;
    end
    check("a_xy_sequence_errors", 32'(xy_bad), 32'd0);
    check("a_hs_runs", 32'(runs), 32'd2);
    check("a_hs_bad_width", 32'(bad_runs), 32'd0);
    check("a_hs_bad_period", 32'(bad_per), 32'd0);
    check("a_decode_violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
